color_match_ctrl: RTL
=====================

// Module: color_match_ctrl
// PURPOSE
//  Game controller on the consumer side of the random colour generator.
//  - Drives the generator's `change` request and latches the new 3-bit colour as the round target.
//  - Shows the target for a fixed time, then waits for a player guess with a timeout.
//  - Scores hits, decrements lives on misses, and ends the game when lives reach 0.
//  - Runs in the 1 Hz domain, the same clock as the generator.
// PARAMETERS
//  SHOW_CYCLES    3  clk1Hz cycles the target is displayed (>=1)
//  TIMEOUT_CYCLES 5  clk1Hz cycles allowed for a guess (>=1)
//  MAX_LIVES      3  lives at game start (1..3)
//  SCORE_W        8  score width; score saturates at all-ones
// PORTS
//  clk1Hz     in   1        1 Hz game clock, shared with the generator
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        level, sampled in IDLE/OVER only; begins a new game
//  color_in   in   3        generator colour output
//  guess_vld  in   1        player guess strobe, already synchronous to clk1Hz
//  guess      in   3        player colour guess, qualified by guess_vld
//  change     out  1        request to generator: advance LFSR at next edge
//  show_en    out  1        1 while target is displayed
//  show_color out  3        target while show_en=1, else 3'b000
//  score      out  SCORE_W  hits this game
//  lives      out  2        remaining lives
//  hit        out  1        1-cycle pulse: correct guess
//  miss       out  1        1-cycle pulse: wrong guess or timeout
//  game_over  out  1        level: held high in OVER
//  state      out  3        FSM state code, for debug LEDs
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, target=0, score=0, lives=MAX_LIVES, timer=0; all pulses/flags 0.
//  FSM codes: IDLE=0 REQ=1 LATCH=2 SHOW=3 WAIT=4 RESULT=5 OVER=6. Code 7 -> IDLE.
//  IDLE: if start=1 -> REQ; on this transition score<=0, lives<=MAX_LIVES.
//  REQ: change=1 (this state only); next -> LATCH. The generator updates its colour on this edge.
//  LATCH: target<=color_in at exit; next -> SHOW with timer<=SHOW_CYCLES-1.
//  SHOW: show_en=1, show_color=target; guesses ignored.
//    - timer==0 -> WAIT with timer<=TIMEOUT_CYCLES-1; else timer--.
//  WAIT: each cycle, in priority order:
//    - guess_vld=1 -> RESULT, verdict=(guess==target).
//    - else timer==0 -> RESULT, verdict=miss.
//    - else timer--.
//    - guess_vld on the same cycle timer==0 counts as a guess, not a timeout.
//  RESULT: hit=verdict, miss=~verdict (combinational from state, 1 cycle).
//    - hit: score<=score+1, saturating at 2^SCORE_W-1.
//    - miss: lives<=lives-1.
//    - Next state: miss && lives==1 -> OVER; else -> REQ.
//  OVER: game_over=1; score and lives (0) held. start=1 -> REQ and resets score/lives, as from IDLE.
//  Round latency: REQ to first WAIT cycle = 2+SHOW_CYCLES cycles.
//  Timeout miss reaches RESULT TIMEOUT_CYCLES cycles after WAIT entry.
//  Identical consecutive targets are legal; there is no re-request.
//  rst mid-round aborts immediately, with no hit/miss pulse.
//  change, show_en, hit, miss, game_over are Moore outputs decoded from state.
// TESTING
//  1. Reset, then start=1 for 1 cycle -> change=1 in exactly one cycle; target=color_in sampled in LATCH;
//     show_en=1 for 3 cycles.
//  2. Guess equal to target on 2nd WAIT cycle -> hit=1 for 1 cycle, score 0->1, lives=3, back to REQ.
//  3. Wrong guess -> miss=1, lives 3->2; no guess -> miss after 5 WAIT cycles.
//  4. Three misses -> game_over=1, lives=0, state=6 held; start=1 -> score=0, lives=3, change pulses.
//  5. guess_vld=1 during SHOW ignored; guess_vld on last WAIT cycle -> judged as guess, not timeout.
//  6. Score forced to 255 (SCORE_W=8) then hit -> stays 255.
//     rst asserted in WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/color_match_ctrl_if.sv
// color_match_ctrl_if: the signal bundle between the colour-match game
// controller and its surroundings (the player, the colour generator and the
// status display).
//   master : drives start, color_in, guess_vld, guess; observes the status.
//   slave  : the controller; drives change, show_en, show_color, score,
//            lives, hit, miss, game_over, state.
// SCORE_W must match the controller's SCORE_W.
interface color_match_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [2:0]         color_in;
  logic               guess_vld;
  logic [2:0]         guess;
  logic               change;
  logic               show_en;
  logic [2:0]         show_color;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               hit;
  logic               miss;
  logic               game_over;
  logic [2:0]         state;

  modport master (
    output start, color_in, guess_vld, guess,
    input  change, show_en, show_color, score, lives, hit, miss, game_over, state
  );

  modport slave (
    input  start, color_in, guess_vld, guess,
    output change, show_en, show_color, score, lives, hit, miss, game_over, state
  );
endinterface

// File: rtl/color_match_ctrl.sv
// color_match_ctrl: colour-match game controller, clocked by the same 1 Hz
// clock as the random colour generator.
// Each round requests a new colour, latches it as the target, shows it for
// SHOW_CYCLES, then waits up to TIMEOUT_CYCLES for a guess. Hits add to a
// saturating score; misses (wrong guess or timeout) cost a life; the game
// ends when the last life is lost.
// Ports:
//   clk1Hz  1 Hz game clock
//   rst     asynchronous, active-high reset
//   bus     slave side of color_match_ctrl_if:
//           in : start, color_in, guess_vld, guess
//           out: change, show_en, show_color, score, lives, hit, miss,
//                game_over, state (all Moore, decoded from registered state)
module color_match_ctrl #(
  parameter int SHOW_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 5,
  parameter int MAX_LIVES      = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               clk1Hz,
  input  logic               rst,
  color_match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LATCH  = 3'd2,
    S_SHOW   = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  // One down-counter serves both the show phase and the guess window.
  localparam int TMAX    = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         LIVES_INI = 2'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic [2:0]         target_q, target_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               verdict_q, verdict_d;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk1Hz or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= 3'b000;
      score_q   <= '0;
      lives_q   <= LIVES_INI;
      timer_q   <= '0;
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      timer_q   <= timer_d;
      verdict_q <= verdict_d;
    end
  end

  always_comb begin
    // NOTE: every value is defaulted to "hold" first so no path through the
    // case statement leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    target_d  = target_q;
    score_d   = score_q;
    lives_d   = lives_q;
    timer_d   = timer_q;
    verdict_d = verdict_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d = S_REQ;
          score_d = '0;
          lives_d = LIVES_INI;
        end
      end
      // The generator advances on the edge leaving REQ, so its new colour
      // is stable throughout LATCH.
      S_REQ: state_d = S_LATCH;
      S_LATCH: begin
        target_d = bus.color_in;
        timer_d  = SHOW_LOAD;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (timer_q == '0) begin
          timer_d = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_WAIT: begin
        // A guess on the final window cycle beats the timeout.
        if (bus.guess_vld) begin
          verdict_d = (bus.guess == target_q);
          state_d   = S_RESULT;
        end else if (timer_q == '0) begin
          verdict_d = 1'b0;
          state_d   = S_RESULT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RESULT: begin
        if (verdict_q) begin
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          state_d = S_REQ;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? S_OVER : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.change     = (state_q == S_REQ);
  assign bus.show_en    = (state_q == S_SHOW);
  assign bus.show_color = (state_q == S_SHOW) ? target_q : 3'b000;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.hit        = (state_q == S_RESULT) &&  verdict_q;
  assign bus.miss       = (state_q == S_RESULT) && !verdict_q;
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.state      = state_q;

endmodule
